acl_slot_scheduler: RTL and testbench
=====================================

// Module: acl_slot_scheduler
// PURPOSE
// Master-side ACL link scheduler. On each master TX slot it picks one active LT_ADDR
// (round-robin), chooses DM1 (data pending, not flow-stopped) or POLL, and requests the
// packet TX path. It then consumes the RX header result (ARQN/FLOW/HEC) to drive
// per-link SEQN, retransmit count, buffer pop and flush. Sits between the LC
// registers/ACL TX buffer and the packet TX/RX datapath inside bt_top.
// PARAMETERS
// NLINK     7   number of slave links; link i maps to LT_ADDR i+1 (1..7)
// MAX_RETX  15  NAK/timeout retransmits allowed before the link packet is flushed
// PORTS
// clk_6M          in   1      6 MHz baseband clock
// rstz            in   1      asynchronous reset, active-high
// sched_en        in   1      scheduler enable; 0 = never leave IDLE
// slot_start_p    in   1      1-cycle pulse, start of master TX slot
// link_active     in   NLINK  link i connected
// data_pend       in   NLINK  ACL TX buffer of link i non-empty
// tx_done_p       in   1      1-cycle pulse, TX packet finished
// rx_done_p       in   1      1-cycle pulse, RX header decoded
// rx_hecgood      in   1      HEC of that header passed
// rx_lt_addr      in   3      decoded LT_ADDR
// rx_arqn         in   1      decoded ARQN (1=ACK)
// rx_flow         in   1      decoded FLOW (1=GO)
// rx_timeout_p    in   1      1-cycle pulse, RX slot ended with no sync/header
// tx_req_p        out  1      1-cycle pulse, start TX of the granted packet
// tx_lt_addr      out  3      LT_ADDR of granted link (valid from tx_req_p until IDLE)
// tx_pk_type      out  4      4'h3 DM1 or 4'h1 POLL
// tx_seqn         out  1      SEQN of granted link
// buf_pop_p       out  1      1-cycle pulse, ACKed packet may be removed from buffer
// buf_flush_p     out  1      1-cycle pulse, packet dropped after MAX_RETX
// buf_sel         out  3      link index for buf_pop_p/buf_flush_p
// overrun_p       out  1      slot_start_p arrived while not IDLE
// sched_idle      out  1      FSM in IDLE
// BEHAVIOUR
// - Reset: FSM=IDLE, rr_ptr=NLINK-1, all seqn/flow_stop/retx_cnt=0; outputs 0 except sched_idle=1.
// - FSM IDLE -> ARB -> TX -> WAIT_RX -> UPD -> IDLE.
// - IDLE: slot_start_p & sched_en -> ARB. Pulse while not IDLE: ignored, overrun_p next cycle.
// - ARB (1 cycle): scan i = rr_ptr+1 .. rr_ptr+NLINK mod NLINK.
//   First i with link_active & data_pend & ~flow_stop -> grant i, DM1.
//   Else first i with link_active -> grant i, POLL. None active -> IDLE, no tx_req_p.
//   rr_ptr <= granted i.
// - TX: tx_req_p on the cycle entering TX (2 cycles after slot_start_p). Leave on tx_done_p.
// - WAIT_RX: rx_done_p & rx_hecgood & rx_lt_addr==granted LT_ADDR -> UPD(good).
//   rx_timeout_p, bad HEC or other LT_ADDR -> UPD(fail). Both in same cycle: rx_done_p wins.
// - UPD (1 cycle), link g:
//   good: flow_stop[g] <= ~rx_flow.
//   DM1 & good & rx_arqn: buf_pop_p, seqn[g] toggles, retx_cnt[g] <= 0.
//   DM1 & (fail | ~rx_arqn): retx_cnt[g]+1. If it reaches MAX_RETX: buf_flush_p, seqn[g]
//   toggles, retx_cnt[g] <= 0. POLL: no pop/flush/seqn/retx change.
//   buf_sel = g during pulses. Return to IDLE.
// - link_active[i] falling clears seqn[i], flow_stop[i], retx_cnt[i] next cycle. Granted link
//   dropping mid-flight: FSM completes normally, UPD suppresses pop/flush.
// - Flow stop only blocks DM1; a flow-stopped link is still POLLed.
// - retx_cnt width = clog2(MAX_RETX+1), never wraps.
// - sched_en low mid-operation: current exchange completes, then stays IDLE.
// - rstz asserted any state: immediate return to reset values.
// TESTING
// - Links 0,2 active, data_pend=3'b101, 3 slots -> tx_lt_addr 1,3,1, DM1 each, tx_seqn 0,0,1 with ACKs.
// - Link 0 only, no data -> POLL lt 1, no buf_pop_p; slot_start_p to tx_req_p = 2 cycles.
// - DM1 link 1, 15 rx_timeout_p -> buf_flush_p once with buf_sel=1, tx_seqn toggles, retx_cnt=0.
// - ACK with rx_flow=0 -> next slot POLL on that link; rx_flow=1 -> DM1 resumes.
// - slot_start_p during WAIT_RX -> overrun_p 1 cycle, no second tx_req_p; link_active drop -> state cleared.
// - rstz pulse in WAIT_RX -> sched_idle=1, tx_req_p=0, all seqn 0, rr_ptr restarts at link 0.

Source files
------------

// File: rtl/acl_slot_scheduler.sv
// Master-side ACL slot scheduler: round-robin LT_ADDR grant, DM1/POLL choice and
// per-link SEQN / retransmit / flow-stop bookkeeping driven by the RX header result.
module acl_slot_scheduler #(
   parameter int unsigned NLINK    = 7,
   parameter int unsigned MAX_RETX = 15
) (
   input  logic             clk_6m_i,
   input  logic             rstz_i,
   input  logic             sched_en_i,
   input  logic             slot_start_p_i,
   input  logic [NLINK-1:0] link_active_i,
   input  logic [NLINK-1:0] data_pend_i,
   input  logic             tx_done_p_i,
   input  logic             rx_done_p_i,
   input  logic             rx_hecgood_i,
   input  logic [2:0]       rx_lt_addr_i,
   input  logic             rx_arqn_i,
   input  logic             rx_flow_i,
   input  logic             rx_timeout_p_i,
   output logic             tx_req_p_o,
   output logic [2:0]       tx_lt_addr_o,
   output logic [3:0]       tx_pk_type_o,
   output logic             tx_seqn_o,
   output logic             buf_pop_p_o,
   output logic             buf_flush_p_o,
   output logic [2:0]       buf_sel_o,
   output logic             overrun_p_o,
   output logic             sched_idle_o
);

   localparam int unsigned IW = (NLINK > 1) ? $clog2(NLINK) : 1;
   localparam int unsigned RW = $clog2(MAX_RETX + 1);
   localparam logic [3:0] PkDm1  = 4'h3;
   localparam logic [3:0] PkPoll = 4'h1;

   typedef enum logic [2:0] {StIdle, StArb, StTx, StWaitRx, StUpd} state_e;
   state_e state_q, state_d;

   logic [IW-1:0]             rr_ptr_q, gnt_q, gnt_d, dm1_idx, poll_idx;
   logic                      dm1_found, poll_found, dm1_q, gnt_lost_q, gnt_lost;
   logic                      upd_good_q, upd_arqn_q, upd_flow_q;
   logic                      tx_req_q, overrun_q, upd_pop, upd_flush;
   logic [NLINK-1:0]          seqn_q, seqn_d, flow_stop_q, flow_stop_d;
   logic [NLINK-1:0][RW-1:0]  retx_q, retx_d;
   logic [RW-1:0]             retx_inc;

   // Round-robin scan starting just after the last granted link; DM1 candidates take priority.
   always_comb begin
      logic [IW-1:0] idx;
      idx        = '0;
      dm1_found  = 1'b0;
      poll_found = 1'b0;
      dm1_idx    = '0;
      poll_idx   = '0;
      for (int k = 1; k <= int'(NLINK); k++) begin
         idx = IW'((int'(rr_ptr_q) + k) % int'(NLINK));
         if (!dm1_found && link_active_i[idx] && data_pend_i[idx] && !flow_stop_q[idx]) begin
            dm1_found = 1'b1;
            dm1_idx   = idx;
         end
         if (!poll_found && link_active_i[idx]) begin
            poll_found = 1'b1;
            poll_idx   = idx;
         end
      end
      gnt_d = dm1_found ? dm1_idx : poll_idx;
   end

   always_ff @(posedge clk_6m_i or posedge rstz_i) begin
      if (rstz_i) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (slot_start_p_i && sched_en_i) state_d = StArb;
         StArb:    state_d = poll_found ? StTx : StIdle;
         StTx:     if (tx_done_p_i) state_d = StWaitRx;
         StWaitRx: if (rx_done_p_i || rx_timeout_p_i) state_d = StUpd;
         StUpd:    state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   assign gnt_lost = gnt_lost_q | ~link_active_i[gnt_q];
   assign retx_inc = retx_q[gnt_q] + RW'(1);

   // Per-link bookkeeping; an inactive link is held cleared regardless of UPD.
   always_comb begin
      seqn_d      = seqn_q;
      flow_stop_d = flow_stop_q;
      retx_d      = retx_q;
      upd_pop     = 1'b0;
      upd_flush   = 1'b0;
      if (state_q == StUpd && !gnt_lost) begin
         if (upd_good_q) flow_stop_d[gnt_q] = ~upd_flow_q;
         if (dm1_q) begin
            if (upd_good_q && upd_arqn_q) begin
               upd_pop        = 1'b1;
               seqn_d[gnt_q]  = ~seqn_q[gnt_q];
               retx_d[gnt_q]  = '0;
            end else if (retx_inc == RW'(MAX_RETX)) begin
               upd_flush      = 1'b1;
               seqn_d[gnt_q]  = ~seqn_q[gnt_q];
               retx_d[gnt_q]  = '0;
            end else begin
               retx_d[gnt_q]  = retx_inc;
            end
         end
      end
      for (int i = 0; i < int'(NLINK); i++) begin
         if (!link_active_i[i]) begin
            seqn_d[i]      = 1'b0;
            flow_stop_d[i] = 1'b0;
            retx_d[i]      = '0;
         end
      end
   end

   always_ff @(posedge clk_6m_i or posedge rstz_i) begin
      if (rstz_i) begin
         rr_ptr_q    <= IW'(NLINK - 1);
         gnt_q       <= '0;
         dm1_q       <= 1'b0;
         gnt_lost_q  <= 1'b0;
         upd_good_q  <= 1'b0;
         upd_arqn_q  <= 1'b0;
         upd_flow_q  <= 1'b0;
         tx_req_q    <= 1'b0;
         overrun_q   <= 1'b0;
         seqn_q      <= '0;
         flow_stop_q <= '0;
         retx_q      <= '0;
      end else begin
         tx_req_q    <= (state_q == StArb) && poll_found;
         overrun_q   <= slot_start_p_i && (state_q != StIdle);
         seqn_q      <= seqn_d;
         flow_stop_q <= flow_stop_d;
         retx_q      <= retx_d;
         if (state_q == StArb && poll_found) begin
            gnt_q      <= gnt_d;
            dm1_q      <= dm1_found;
            rr_ptr_q   <= gnt_d;
            gnt_lost_q <= 1'b0;
         end else if (state_q != StIdle && !link_active_i[gnt_q]) begin
            gnt_lost_q <= 1'b1;
         end
         if (state_q == StWaitRx && (rx_done_p_i || rx_timeout_p_i)) begin
            upd_good_q <= rx_done_p_i && rx_hecgood_i && (rx_lt_addr_i == 3'(gnt_q) + 3'd1);
            upd_arqn_q <= rx_arqn_i;
            upd_flow_q <= rx_flow_i;
         end
      end
   end

   always_comb begin
      sched_idle_o  = (state_q == StIdle);
      tx_req_p_o    = tx_req_q;
      overrun_p_o   = overrun_q;
      tx_lt_addr_o  = 3'd0;
      tx_pk_type_o  = 4'h0;
      tx_seqn_o     = 1'b0;
      buf_pop_p_o   = upd_pop;
      buf_flush_p_o = upd_flush;
      buf_sel_o     = 3'd0;
      if (state_q == StTx || state_q == StWaitRx || state_q == StUpd) begin
         tx_lt_addr_o = 3'(gnt_q) + 3'd1;
         tx_pk_type_o = dm1_q ? PkDm1 : PkPoll;
         tx_seqn_o    = seqn_q[gnt_q];
      end
      if (upd_pop || upd_flush) buf_sel_o = 3'(gnt_q);
   end

endmodule

// File: tb/tb_acl_slot_scheduler.sv
// Directed bench for acl_slot_scheduler: arbitration order, DM1/POLL choice, ARQ
// bookkeeping, flush, flow stop, overrun, link drop and mid-exchange reset.
module tb_acl_slot_scheduler;

   logic       clk = 1'b0;
   logic       rst, sched_en, slot, tx_done, rx_done, rx_hec, rx_arqn, rx_flow, timeout;
   logic [6:0] link_active, data_pend;
   logic [2:0] rx_lt;
   logic       tx_req, tx_seqn, pop, flush, overrun, idle;
   logic [2:0] tx_lt, sel;
   logic [3:0] tx_pt;

   int checks = 0;
   int errors = 0;

   // Captured results of the last exchange
   logic       c_req, c_sq, c_pop, c_flush;
   logic [2:0] c_lt, c_sel;
   logic [3:0] c_pt;
   int         c_lat;

   always #5 clk = ~clk;

   acl_slot_scheduler #(.NLINK(7), .MAX_RETX(15)) dut (
      .clk_6m_i(clk), .rstz_i(rst), .sched_en_i(sched_en), .slot_start_p_i(slot),
      .link_active_i(link_active), .data_pend_i(data_pend), .tx_done_p_i(tx_done),
      .rx_done_p_i(rx_done), .rx_hecgood_i(rx_hec), .rx_lt_addr_i(rx_lt),
      .rx_arqn_i(rx_arqn), .rx_flow_i(rx_flow), .rx_timeout_p_i(timeout),
      .tx_req_p_o(tx_req), .tx_lt_addr_o(tx_lt), .tx_pk_type_o(tx_pt), .tx_seqn_o(tx_seqn),
      .buf_pop_p_o(pop), .buf_flush_p_o(flush), .buf_sel_o(sel), .overrun_p_o(overrun),
      .sched_idle_o(idle)
   );

   task automatic do_reset();
      rst = 1'b1; sched_en = 1'b1; slot = 1'b0; tx_done = 1'b0; rx_done = 1'b0;
      rx_hec = 1'b0; rx_arqn = 1'b0; rx_flow = 1'b0; timeout = 1'b0; rx_lt = 3'd0;
      link_active = 7'd0; data_pend = 7'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One full slot exchange; called aligned 1 time unit after a rising edge.
   task automatic exchange(input logic [2:0] rlt, input logic hec, input logic arqn,
                           input logic flow, input logic tmo);
      c_req = 0; c_lat = 0; c_lt = 0; c_pt = 0; c_sq = 0; c_pop = 0; c_flush = 0; c_sel = 0;
      slot = 1'b1;
      @(posedge clk); #1 slot = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (tx_req) begin
            c_req = 1'b1; c_lat = i + 1; c_lt = tx_lt; c_pt = tx_pt; c_sq = tx_seqn;
            break;
         end
      end
      if (!c_req) begin
         @(posedge clk); #1;
         return;
      end
      @(posedge clk); #1 tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;
      if (tmo) timeout = 1'b1;
      else begin
         rx_done = 1'b1; rx_hec = hec; rx_lt = rlt; rx_arqn = arqn; rx_flow = flow;
      end
      @(posedge clk); #1 rx_done = 1'b0; timeout = 1'b0;
      @(negedge clk);
      c_pop = pop; c_flush = flush; c_sel = sel;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({tx_req, tx_lt, tx_pt, tx_seqn, pop, flush, sel, overrun, idle} !== 16'h0001) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0001",
                  {tx_req, tx_lt, tx_pt, tx_seqn, pop, flush, sel, overrun, idle});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_lt[3]  = '{3'd1, 3'd3, 3'd1};
      logic       exp_sq[3]  = '{1'b0, 1'b0, 1'b1};
      logic [2:0] exp_sel[3] = '{3'd0, 3'd2, 3'd0};
      do_reset();
      link_active = 7'b0000101; data_pend = 7'b0000101;
      for (int s = 0; s < 3; s++) begin
         exchange(exp_lt[s], 1'b1, 1'b1, 1'b1, 1'b0);
         checks++;
         if ({c_req, c_lt, c_pt, c_sq} !== {1'b1, exp_lt[s], 4'h3, exp_sq[s]}) begin
            errors++;
            $display("FAIL rr_grant slot=%0d got req=%b lt=%0d pt=%h sq=%b exp lt=%0d pt=3 sq=%b",
                     s, c_req, c_lt, c_pt, c_sq, exp_lt[s], exp_sq[s]);
         end
         checks++;
         if ({c_pop, c_flush, c_sel} !== {1'b1, 1'b0, exp_sel[s]}) begin
            errors++;
            $display("FAIL rr_pop slot=%0d got pop=%b flush=%b sel=%0d exp pop=1 flush=0 sel=%0d",
                     s, c_pop, c_flush, c_sel, exp_sel[s]);
         end
      end
   endtask

   task automatic test_poll();
      do_reset();
      link_active = 7'b0000001; data_pend = 7'b0000000;
      for (int s = 0; s < 2; s++) begin
         exchange(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
         checks++;
         if ({c_req, c_lt, c_pt, c_sq, c_pop} !== {1'b1, 3'd1, 4'h1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL poll slot=%0d got req=%b lt=%0d pt=%h sq=%b pop=%b exp 1 1 1 0 0",
                     s, c_req, c_lt, c_pt, c_sq, c_pop);
         end
         checks++;
         if (c_lat != 2) begin
            errors++;
            $display("FAIL poll_latency got=%0d exp=2", c_lat);
         end
      end
      sched_en = 1'b0;
      exchange(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (c_req !== 1'b0) begin
         errors++;
         $display("FAIL sched_disabled got req=%b exp=0", c_req);
      end
      sched_en = 1'b1; link_active = 7'd0;
      exchange(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({c_req, idle} !== 2'b01) begin
         errors++;
         $display("FAIL no_active got req=%b idle=%b exp req=0 idle=1", c_req, idle);
      end
   endtask

   task automatic test_flush();
      do_reset();
      link_active = 7'b0000010; data_pend = 7'b0000010;
      for (int r = 0; r < 2; r++) begin
         for (int k = 1; k <= 15; k++) begin
            exchange(3'd2, 1'b1, 1'b1, 1'b1, 1'b1);
            checks++;
            if ({c_req, c_lt, c_pt, c_sq} !== {1'b1, 3'd2, 4'h3, r[0]}) begin
               errors++;
               $display("FAIL flush_tx round=%0d k=%0d got lt=%0d pt=%h sq=%b exp lt=2 pt=3 sq=%b",
                        r, k, c_lt, c_pt, c_sq, r[0]);
            end
            checks++;
            if ({c_flush, c_pop, c_sel} !== ((k == 15) ? 5'b10001 : 5'b00000)) begin
               errors++;
               $display("FAIL flush_pulse round=%0d k=%0d got flush=%b pop=%b sel=%0d exp flush=%0d",
                        r, k, c_flush, c_pop, c_sel, (k == 15));
            end
         end
      end
   endtask

   task automatic test_flow();
      do_reset();
      link_active = 7'b0000001; data_pend = 7'b0000001;
      exchange(3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({c_pt, c_pop, c_sq} !== {4'h3, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL flow_first got pt=%h pop=%b sq=%b exp pt=3 pop=1 sq=0", c_pt, c_pop, c_sq);
      end
      exchange(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({c_lt, c_pt, c_pop} !== {3'd1, 4'h1, 1'b0}) begin
         errors++;
         $display("FAIL flow_stopped got lt=%0d pt=%h pop=%b exp lt=1 pt=1 pop=0", c_lt, c_pt, c_pop);
      end
      exchange(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({c_pt, c_sq, c_pop} !== {4'h3, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL flow_resume got pt=%h sq=%b pop=%b exp pt=3 sq=1 pop=1", c_pt, c_sq, c_pop);
      end
   endtask

   task automatic test_nak();
      do_reset();
      link_active = 7'b0000001; data_pend = 7'b0000001;
      exchange(3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({c_pop, c_flush} !== 2'b00) begin
         errors++;
         $display("FAIL nak got pop=%b flush=%b exp 0 0", c_pop, c_flush);
      end
      exchange(3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({c_pop, c_sq} !== 2'b00) begin
         errors++;
         $display("FAIL bad_hec got pop=%b sq=%b exp 0 0", c_pop, c_sq);
      end
      exchange(3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({c_pop, c_sq} !== 2'b00) begin
         errors++;
         $display("FAIL wrong_lt got pop=%b sq=%b exp 0 0", c_pop, c_sq);
      end
      exchange(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({c_pop, c_sq, c_sel} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL ack_after_nak got pop=%b sq=%b sel=%0d exp 1 0 0", c_pop, c_sq, c_sel);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      link_active = 7'b0000001; data_pend = 7'b0000001;
      slot = 1'b1;
      @(posedge clk); #1 slot = 1'b0;
      @(posedge clk); #1 tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0; slot = 1'b1;
      @(posedge clk); #1 slot = 1'b0;
      @(negedge clk);
      checks++;
      if ({overrun, tx_req} !== 2'b10) begin
         errors++;
         $display("FAIL overrun_pulse got overrun=%b req=%b exp 1 0", overrun, tx_req);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({overrun, tx_req, idle} !== 3'b000) begin
         errors++;
         $display("FAIL overrun_after got overrun=%b req=%b idle=%b exp 0 0 0", overrun, tx_req, idle);
      end
      @(posedge clk); #1 rx_done = 1'b1; rx_hec = 1'b1; rx_lt = 3'd1; rx_arqn = 1'b1; rx_flow = 1'b1;
      @(posedge clk); #1 rx_done = 1'b0;
      @(negedge clk);
      checks++;
      if ({pop, sel} !== 4'b1000) begin
         errors++;
         $display("FAIL overrun_ack got pop=%b sel=%0d exp 1 0", pop, sel);
      end
      @(posedge clk); #1 link_active = 7'd0;
      @(posedge clk); #1 link_active = 7'b0000001;
      exchange(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({c_req, c_pt, c_sq} !== {1'b1, 4'h3, 1'b0}) begin
         errors++;
         $display("FAIL link_drop_clear got req=%b pt=%h sq=%b exp 1 3 0", c_req, c_pt, c_sq);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      link_active = 7'b0000111; data_pend = 7'b0000111;
      exchange(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      slot = 1'b1;
      @(posedge clk); #1 slot = 1'b0;
      @(posedge clk); #1 tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({idle, tx_req, tx_lt, tx_seqn} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_mid got idle=%b req=%b lt=%0d sq=%b exp 1 0 0 0",
                  idle, tx_req, tx_lt, tx_seqn);
      end
      @(posedge clk); #1 rst = 1'b0;
      exchange(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({c_req, c_lt, c_sq} !== {1'b1, 3'd1, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_restart got req=%b lt=%0d sq=%b exp 1 1 0", c_req, c_lt, c_sq);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_round_robin();
      test_poll();
      test_flush();
      test_flow();
      test_nak();
      test_overrun();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
